// File: rtl/sayac_mem_pkg.sv
// sayac_mem_pkg: shared types and constants for the SAYAC memory-side controller.
package sayac_mem_pkg;
    localparam int DATA_W = 16;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {OP_RD, OP_WR} op_t;
    typedef logic [3:0] wait_cnt_t;
endpackage

// File: rtl/sayac_mem_ctrl_if.sv
// sayac_mem_ctrl_if: processor-to-memory request/ready bus of the SAYAC core.
interface sayac_mem_ctrl_if;
    import sayac_mem_pkg::*;
    logic              readMM;
    logic              writeMM;
    logic              readInst;
    logic [DATA_W-1:0] addrBus;
    logic [DATA_W-1:0] dataBusOut;
    logic [DATA_W-1:0] dataBusIn;
    logic              readyMEM;
    modport master (output readMM, writeMM, readInst, addrBus, dataBusOut, input dataBusIn, readyMEM);
    modport slave  (input readMM, writeMM, readInst, addrBus, dataBusOut, output dataBusIn, readyMEM);
endinterface

// File: rtl/sayac_mem_ctrl.sv
// sayac_mem_ctrl: sequences a synchronous single-port SRAM with programmable wait states
// behind a 4-phase ready handshake; out-of-range addresses complete without an SRAM access.
module sayac_mem_ctrl
    import sayac_mem_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter int          RD_WAIT   = 2,
    parameter int          WR_WAIT   = 1,
    parameter logic [15:0] OOR_RDATA = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    sayac_mem_ctrl_if.slave   bus,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [DATA_W-1:0] fetch_cnt,
    output logic              oor_err
);
    localparam wait_cnt_t RD_CNT = wait_cnt_t'(RD_WAIT);
    localparam wait_cnt_t WR_CNT = wait_cnt_t'(WR_WAIT);

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    wait_cnt_t         cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic              inst_q, inst_d;
    logic              oor_q, oor_d;
    logic              req, oor;

    assign req = bus.readMM | bus.writeMM;
    assign oor = |(bus.addrBus >> ADDR_W);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        inst_d  = inst_q;
        oor_d   = oor_q;
        case (state_q)
            IDLE: if (req) begin
                op_d    = bus.writeMM ? OP_WR : OP_RD;
                addr_d  = bus.addrBus[ADDR_W-1:0];
                wdata_d = bus.dataBusOut;
                inst_d  = bus.readInst;
                if (oor) begin
                    state_d = DONE;
                    oor_d   = 1'b1;
                    rdata_d = bus.writeMM ? rdata_q : OOR_RDATA;
                end else begin
                    state_d = ACCESS;
                    cnt_d   = bus.writeMM ? WR_CNT : RD_CNT;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    rdata_d = (op_q == OP_RD) ? sram_rdata : rdata_q;
                end
            end
            DONE:    state_d = req ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
        // counts any completed fetch, including one that hit an out-of-range address
        fetch_cnt_d = (state_d == DONE && state_q != DONE && op_d == OP_RD && inst_d) ? fetch_cnt_q + 16'd1 : fetch_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            op_q        <= OP_RD;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            inst_q      <= 1'b0;
            oor_q       <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            inst_q      <= inst_d;
            oor_q       <= oor_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // the counter still holds its load value only in the first ACCESS cycle
    assign sram_ce      = state_q == ACCESS;
    assign sram_we      = sram_ce && op_q == OP_WR && cnt_q == WR_CNT;
    assign sram_addr    = addr_q;
    assign sram_wdata   = wdata_q;
    assign bus.readyMEM = state_q == DONE;
    assign bus.dataBusIn = rdata_q;
    assign fetch_cnt    = fetch_cnt_q;
    assign oor_err      = oor_q;
endmodule
